motor_cmd_ctrl: RTL
===================

Name: motor_cmd_ctrl

Overview:
Command-issuing end of the 2-bit motor command interface. Converts user up/down/stop buttons and the registered limit-switch feedback (TopeA_S/TopeB_S from the motor driver) into the `cmd` word consumed by the motor driver. Sits in the house/top-level controller. Adds travel timeout, direction-reversal dead time, position tracking and fault latching.

Parameters:
TIMEOUT_CYC, 250_000_000, maximum cycles allowed in UP or DOWN before fault (5 s at 50 MHz).
DEAD_CYC, 5_000_000, cycles `cmd` is held at stop between opposite-direction commands.
CNT_W, 28, width of the shared travel/dead-time counter; must hold max(TIMEOUT_CYC, DEAD_CYC).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
btn_up  in  1  up request; level, debounced upstream; rising edge acts.
btn_down  in  1  down request; level; rising edge acts.
btn_stop  in  1  stop / fault-clear; level; rising edge acts.
tope_a  in  1  upper limit reached (from motor driver TopeA_S).
tope_b  in  1  lower limit reached (from motor driver TopeB_S).
cmd  out  2  00 stop, 01 up, 10 down; 11 never driven.
busy  out  1  high in UP, DOWN, DEAD.
pos  out  2  00 unknown, 01 top, 10 bottom.
fault  out  1  latched fault indicator.

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `reset`. All state changes on the posedge of `clk`.
- Reset:
  - State goes to IDLE; cmd=00, busy=0, pos=00, fault=0, counter=0.
  - Button-history registers reset to 1, so a button held through reset does not act until it is released and pressed again.
  - Reset mid-motion drops cmd to 00 at that edge.
- Edges: a request is `btn & !btn_prev`. All outputs are registered. A request sampled at edge k changes cmd at edge k (visible cycle k+1).
- Request priority within one cycle: stop > (up and down together, treated as stop) > up/down.
- States: IDLE, UP, DOWN, DEAD, FAULT.
- IDLE:
  - up request with !tope_a -> UP, cmd=01, pos=00.
  - up request with tope_a=1 -> stay IDLE, pos=01.
  - Down request is symmetric (tope_b, cmd=10, pos=10).
- UP:
  - tope_a=1 -> IDLE, cmd=00, pos=01.
  - stop request -> IDLE, cmd=00, pos stays 00.
  - down request -> DEAD with target=DOWN, cmd=00.
  - Repeated up request is ignored.
  - DOWN is symmetric.
- DEAD:
  - cmd=00 for exactly DEAD_CYC cycles, then the target state with its cmd. A target whose limit is already active goes to IDLE instead.
  - stop request -> IDLE.
  - An opposite request retargets without restarting the count.
- Counter:
  - Cleared on every entry to UP, DOWN or DEAD; increments each cycle in those states.
  - In UP/DOWN, reaching TIMEOUT_CYC-1 with no limit active -> FAULT: cmd=00, fault=1, busy=0.
  - If the limit and the timeout occur in the same cycle, the limit wins (normal stop, no fault).
- tope_a and tope_b both 1 in any non-FAULT state -> FAULT next edge (sensor fault); pos=00.
- FAULT:
  - cmd=00; up/down requests are ignored.
  - stop request -> IDLE, fault=0, pos=00.
- cmd never switches directly between 01 and 10; a 00 phase of at least DEAD_CYC cycles always separates them.

Decomposition:
- Shared package motor_pkg holds:
  - cmd encodings CMD_STOP/CMD_UP/CMD_DOWN;
  - pos encodings POS_UNK/POS_TOP/POS_BOT;
  - state encoding.
- The motor driver uses the same cmd constants.
- One sub-module: edge_rise (registered rising-edge detector, history reset to 1), instantiated three times.

Test Plan:
All scenarios use TIMEOUT_CYC=20, DEAD_CYC=4.
1. Up with limit: reset, btn_up pulse at edge 5, tope_a high at edge 15 -> cmd=01 from edge 5; cmd=00, pos=01, busy=0 from edge 15; fault=0.
2. Reversal: moving up, btn_down at edge t -> cmd=00 during edges t..t+3; cmd=10 at edge t+4. btn_stop during DEAD -> cmd stays 00, state IDLE.
3. Timeout: btn_down, tope_b held 0 -> cmd=10 for 20 cycles then 00, fault=1; btn_up ignored; btn_stop -> fault=0, pos=00. Repeat with tope_b rising on the timeout cycle -> no fault, pos=10.
4. IDLE corner cases: btn_up and btn_down rising in the same cycle -> cmd stays 00; tope_a=1 and btn_up -> cmd stays 00, pos=01.
5. Sensor fault: moving down, tope_a and tope_b both driven 1 -> cmd=00, fault=1 at the next edge.
6. Reset: reset asserted while btn_up held 1 -> cmd=00 and stays 00 after release; btn_up released and pressed again -> cmd=01. Reset asserted mid-DOWN -> cmd=00 at that edge.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: encodings shared between the command issuer and the motor driver.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
//
// Contents: cmd word encodings, position encodings, controller state encoding
// and a decode from controller state to the cmd word it drives.
package motor_pkg;

   // 2-bit motor command word; 2'b11 is never issued.
   localparam logic [1:0] CMD_STOP = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DOWN = 2'b10;

   // Last known carriage position.
   localparam logic [1:0] POS_UNK  = 2'b00;
   localparam logic [1:0] POS_TOP  = 2'b01;
   localparam logic [1:0] POS_BOT  = 2'b10;

   // Controller states.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_UP    = 3'd1;
   localparam logic [2:0] ST_DOWN  = 3'd2;
   localparam logic [2:0] ST_DEAD  = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   // Only the two travel states ever drive the motor.
   function automatic logic [1:0] cmd_of_state(input logic [2:0] st);
      case (st)
         ST_UP:   cmd_of_state = CMD_UP;
         ST_DOWN: cmd_of_state = CMD_DOWN;
         default: cmd_of_state = CMD_STOP;
      endcase
   endfunction

endpackage

// File: rtl/edge_rise.sv
// edge_rise: rising-edge detector for a debounced button level.
// Latency: req is combinational from btn against the registered history (acts on the same edge).
// Backpressure: none; a pulse is one cycle wide and is not held.
//
// Ports: clk, reset (sync, active-high), btn (level in), req (one-cycle request out).
// History resets to 1 so a button held through reset must be released and
// pressed again before it produces a request.
module edge_rise (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic req
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b1;
      end else begin
         prev <= btn;
      end
   end

   assign req = btn & ~prev;

endmodule

// File: rtl/motor_cmd_ctrl.sv
// motor_cmd_ctrl: turns up/down/stop buttons and limit feedback into the motor cmd word.
// Latency: a request or limit sampled at edge k changes the registered outputs at edge k.
// Backpressure: none; requests arriving in states that cannot act on them are dropped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   btn_up/down/stop      debounced button levels; only rising edges act
//   tope_a / tope_b       upper / lower limit switch feedback
//   cmd                   00 stop, 01 up, 10 down
//   busy                  high while travelling or in reversal dead time
//   pos                   00 unknown, 01 top, 10 bottom
//   fault                 latched timeout / sensor fault, cleared by stop
module motor_cmd_ctrl
   import motor_pkg::*;
#(
   parameter int TIMEOUT_CYC = 250_000_000,
   parameter int DEAD_CYC    = 5_000_000,
   parameter int CNT_W       = 28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   input  logic       tope_a,
   input  logic       tope_b,
   output logic [1:0] cmd,
   output logic       busy,
   output logic [1:0] pos,
   output logic       fault
);

   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

   logic             rq_up, rq_down, rq_stop;
   logic             stop_any, go_up, go_down;

   logic [2:0]       st, st_n;
   logic             tgt_down, tgt_down_n;   // direction to resume after dead time
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       pos_n;

   edge_rise u_edge_up   (.clk(clk), .reset(reset), .btn(btn_up),   .req(rq_up));
   edge_rise u_edge_down (.clk(clk), .reset(reset), .btn(btn_down), .req(rq_down));
   edge_rise u_edge_stop (.clk(clk), .reset(reset), .btn(btn_stop), .req(rq_stop));

   // Simultaneous up and down is ambiguous, so it is handled as a stop.
   assign stop_any = rq_stop | (rq_up & rq_down);
   assign go_up    = rq_up   & ~stop_any;
   assign go_down  = rq_down & ~stop_any;

   always_comb begin
      st_n       = st;
      tgt_down_n = tgt_down;
      cnt_n      = cnt + 1'b1;
      pos_n      = pos;

      if (st != ST_FAULT && tope_a && tope_b) begin
         // Both limits at once cannot be real: treat as a sensor fault.
         st_n  = ST_FAULT;
         pos_n = POS_UNK;
      end else begin
         case (st)
            ST_IDLE: begin
               if (go_up) begin
                  if (tope_a) begin
                     pos_n = POS_TOP;
                  end else begin
                     st_n  = ST_UP;
                     cnt_n = '0;
                     pos_n = POS_UNK;
                  end
               end else if (go_down) begin
                  if (tope_b) begin
                     pos_n = POS_BOT;
                  end else begin
                     st_n  = ST_DOWN;
                     cnt_n = '0;
                     pos_n = POS_UNK;
                  end
               end
            end

            ST_UP: begin
               // Limit is checked before timeout so a limit on the last cycle is a clean stop.
               if (tope_a) begin
                  st_n  = ST_IDLE;
                  pos_n = POS_TOP;
               end else if (stop_any) begin
                  st_n = ST_IDLE;
               end else if (go_down) begin
                  st_n       = ST_DEAD;
                  tgt_down_n = 1'b1;
                  cnt_n      = '0;
               end else if (cnt == TO_LAST) begin
                  st_n = ST_FAULT;
               end
            end

            ST_DOWN: begin
               if (tope_b) begin
                  st_n  = ST_IDLE;
                  pos_n = POS_BOT;
               end else if (stop_any) begin
                  st_n = ST_IDLE;
               end else if (go_up) begin
                  st_n       = ST_DEAD;
                  tgt_down_n = 1'b0;
                  cnt_n      = '0;
               end else if (cnt == TO_LAST) begin
                  st_n = ST_FAULT;
               end
            end

            ST_DEAD: begin
               if (stop_any) begin
                  st_n = ST_IDLE;
               end else begin
                  // Retargeting keeps the running count so dead time is never extended.
                  if (go_up)   tgt_down_n = 1'b0;
                  if (go_down) tgt_down_n = 1'b1;
                  if (cnt == DEAD_LAST) begin
                     if (tgt_down_n) begin
                        if (tope_b) begin
                           st_n  = ST_IDLE;
                           pos_n = POS_BOT;
                        end else begin
                           st_n  = ST_DOWN;
                           cnt_n = '0;
                           pos_n = POS_UNK;
                        end
                     end else begin
                        if (tope_a) begin
                           st_n  = ST_IDLE;
                           pos_n = POS_TOP;
                        end else begin
                           st_n  = ST_UP;
                           cnt_n = '0;
                           pos_n = POS_UNK;
                        end
                     end
                  end
               end
            end

            ST_FAULT: begin
               if (stop_any) begin
                  st_n  = ST_IDLE;
                  pos_n = POS_UNK;
               end
            end

            default: begin
               st_n  = ST_IDLE;
               pos_n = POS_UNK;
            end
         endcase
      end

      // Counter only runs in the timed states.
      if (st_n != ST_UP && st_n != ST_DOWN && st_n != ST_DEAD) begin
         cnt_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= ST_IDLE;
         tgt_down <= 1'b0;
         cnt      <= '0;
         pos      <= POS_UNK;
         cmd      <= CMD_STOP;
         busy     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         st       <= st_n;
         tgt_down <= tgt_down_n;
         cnt      <= cnt_n;
         pos      <= pos_n;
         // Outputs are registered from the next state so they change on the acting edge.
         cmd      <= cmd_of_state(st_n);
         busy     <= (st_n == ST_UP) || (st_n == ST_DOWN) || (st_n == ST_DEAD);
         fault    <= (st_n == ST_FAULT);
      end
   end

endmodule
